wb_stage_cp0: RTL

//  Write-back stage: last pipeline stage, directly after the MEM stage. Registers MEM's 110-bit result bus and retires it
//  to the GPR file and debug trace. Holds the CP0 register set: Status, Cause, EPC, BadVAddr, Count and Compare.

---
 rtl/wb_stage_cp0.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_stage_cp0.sv
// wb_stage_cp0: write-back stage with CP0 register set, exception/interrupt/ERET commit
module wb_stage_cp0 #(
  parameter int          MS_TO_WS_BUS_WD = 110,
  parameter logic [4:0]  NO_EX           = 5'h1f,
  parameter logic [31:0] EX_ENTRY        = 32'hbfc00380
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       ms_mtc0,
  input  logic                       ms_mfc0,
  input  logic [7:0]                 ms_cp0_addr,
  input  logic [5:0]                 ext_int,
  output logic                       ws_allowin,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [4:0]                 WB_dest,
  output logic [31:0]                WB_dest_data,
  output logic                       WS_EX,
  output logic                       ERET,
  output logic [31:0]                ex_target,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);
  localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_CMP = 8'h58,
                         A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;
  localparam logic [MS_TO_WS_BUS_WD-1:0] BUS_RST = {{(MS_TO_WS_BUS_WD-77){1'b0}}, NO_EX, 72'b0};
  logic                       ws_valid, mtc0_r, mfc0_r;
  logic [MS_TO_WS_BUS_WD-1:0] bus_r;
  logic [7:0]                 addr_r;
  logic                       pc_error, eret, bd, gr_we;
  logic [31:0]                bus_bva, result, pc;
  logic [4:0]                 ex_code, dest;
  logic [7:0]                 im, ip;
  logic                       exl, ie, c_bd, ti, tick;
  logic [1:0]                 sw_ip;
  logic [4:0]                 exc, code;
  logic [31:0]                epc, badvaddr, count, compare, status, cause, cp0_rdata;
  logic                       int_req, flush, wen;
  assign {pc_error, bus_bva, ex_code, eret, bd, gr_we, dest, result, pc} = bus_r;
  assign status    = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
  assign ip        = {ext_int[5] | ti, ext_int[4:0], sw_ip};
  assign cause     = {c_bd, ti, 14'b0, ip, 1'b0, exc, 2'b0};
  assign int_req   = ie & ~exl & |(ip & im);
  assign WS_EX     = ws_valid & ((ex_code != NO_EX) | int_req);
  assign ERET      = ws_valid & eret & ~WS_EX;
  assign flush     = WS_EX | ERET;
  assign code      = int_req ? 5'd0 : ex_code;
  assign wen       = ws_valid & mtc0_r & ~WS_EX;
  assign cp0_rdata = addr_r == A_STATUS ? status :
                     addr_r == A_CAUSE  ? cause :
                     addr_r == A_EPC    ? epc :
                     addr_r == A_BADV   ? badvaddr :
                     addr_r == A_COUNT  ? count :
                     addr_r == A_CMP    ? compare : 32'b0;
  assign ws_allowin        = 1'b1;
  assign rf_we             = ws_valid & gr_we & ~WS_EX;
  assign rf_waddr          = dest;
  assign rf_wdata          = mfc0_r ? cp0_rdata : result;
  assign WB_dest           = ws_valid ? dest : 5'd0;
  assign WB_dest_data      = ws_valid ? rf_wdata : 32'd0;
  assign ex_target         = WS_EX ? EX_ENTRY : epc;
  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = dest;
  assign debug_wb_rf_wdata = rf_wdata;
  // capture MEM's instruction unless a flush is committing and discarding it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid <= 1'b0;
      bus_r    <= BUS_RST;
      mtc0_r   <= 1'b0;
      mfc0_r   <= 1'b0;
      addr_r   <= 8'd0;
    end else begin
      ws_valid <= ms_to_ws_valid & ~flush;
      if (ms_to_ws_valid & ~flush) begin
        bus_r  <= ms_to_ws_bus;
        mtc0_r <= ms_mtc0;
        mfc0_r <= ms_mfc0;
        addr_r <= ms_cp0_addr;
      end
    end
  end
  // Status/Cause/EPC/BadVAddr: exception beats ERET beats MTC0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= 8'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      c_bd     <= 1'b0;
      sw_ip    <= 2'd0;
      exc      <= 5'd0;
      epc      <= 32'd0;
      badvaddr <= 32'd0;
    end else if (WS_EX) begin
      exl <= 1'b1;
      exc <= code;
      if (!exl) begin
        epc  <= bd ? pc - 32'd4 : pc;
        c_bd <= bd;
      end
      if (code == 5'd4 || code == 5'd5) badvaddr <= pc_error ? pc : bus_bva;
    end else if (ERET) begin
      exl <= 1'b0;
    end else if (wen) begin
      if (addr_r == A_STATUS) {im, exl, ie} <= {result[15:8], result[1:0]};
      if (addr_r == A_CAUSE) sw_ip <= result[9:8];
      if (addr_r == A_EPC) epc <= result;
    end
  end
  // half-rate Count, Compare and timer flag; MTC0 wins over increment and match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick    <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      tick    <= ~tick;
      count   <= (wen && addr_r == A_COUNT) ? result : count + {31'b0, tick};
      compare <= (wen && addr_r == A_CMP) ? result : compare;
      ti      <= (wen && addr_r == A_CMP) ? 1'b0 : (count == compare) ? 1'b1 : ti;
    end
  end
endmodule
